// File: rtl/vrvv_pkg.sv
// Shared vector-unit definitions: encodings, defaults, write-back FSM states
// and the LMUL decoder also used by the read-side grouping selector.
package vrvv_pkg;

  localparam int unsigned VlenDefault = 64;
  localparam int unsigned NregDefault = 32;
  localparam int unsigned VlWDefault  = 9;

  // vlmul encodings
  localparam logic [2:0] LmulM1   = 3'b000;
  localparam logic [2:0] LmulM2   = 3'b001;
  localparam logic [2:0] LmulM4   = 3'b010;
  localparam logic [2:0] LmulM8   = 3'b011;
  localparam logic [2:0] LmulRsvd = 3'b100;
  localparam logic [2:0] LmulMf8  = 3'b101;
  localparam logic [2:0] LmulMf4  = 3'b110;
  localparam logic [2:0] LmulMf2  = 3'b111;

  // vsew encodings
  localparam logic [2:0] Sew8  = 3'b000;
  localparam logic [2:0] Sew16 = 3'b001;
  localparam logic [2:0] Sew32 = 3'b010;
  localparam logic [2:0] Sew64 = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDone,
    StErr
  } wb_state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] regs;
  } lmul_dec_t;

  // Registers per group; fractional LMUL still occupies one register.
  function automatic lmul_dec_t lmul_regs(input logic [2:0] enc);
    lmul_dec_t d;
    d.legal = 1'b1;
    d.regs  = 4'd1;
    case (enc)
      LmulM2:   d.regs = 4'd2;
      LmulM4:   d.regs = 4'd4;
      LmulM8:   d.regs = 4'd8;
      LmulRsvd: d.legal = 1'b0;
      default:  d.regs = 4'd1;
    endcase
    return d;
  endfunction

  function automatic logic sew_legal(input logic [2:0] enc);
    return ~enc[2];
  endfunction

endpackage

// File: rtl/vwb_byte_mask.sv
// Per-byte write enables for one register beat: a byte is enabled when the
// element it belongs to lies below vl, leaving tail elements undisturbed.
module vwb_byte_mask #(
  parameter int unsigned VLEN = 64,
  parameter int unsigned VL_W = 9
) (
  input  logic [2:0]        beat_i,
  input  logic [1:0]        sew_i,
  input  logic [VL_W-1:0]   vl_i,
  output logic [VLEN/8-1:0] wbe_o
);

  localparam int unsigned NB = VLEN / 8;
  // Three extra bits so beat*elems_per_reg + offset never wraps.
  localparam int unsigned IW = VL_W + 3;

  logic [IW-1:0] epr;
  logic [IW-1:0] base;

  // Element index of each byte compared against vl.
  always_comb begin
    wbe_o = '0;
    epr   = IW'(NB) >> sew_i;
    base  = IW'(beat_i) * epr;
    for (int b = 0; b < NB; b++) begin
      wbe_o[b] = (base + (IW'(b) >> sew_i)) < IW'(vl_i);
    end
  end

endmodule

// File: rtl/vwb_sequencer.sv
// Vector write-back sequencer: turns a stream of vALU result beats into one
// register-file write per register of the destination LMUL group.
module vwb_sequencer
  import vrvv_pkg::*;
#(
  parameter int unsigned VLEN = VlenDefault,
  parameter int unsigned NREG = NregDefault,
  parameter int unsigned VL_W = VlWDefault
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [$clog2(NREG)-1:0] cmd_vd,
  input  logic [2:0]              cmd_lmul_enc,
  input  logic [2:0]              cmd_sew_enc,
  input  logic [VL_W-1:0]         cmd_vl,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [VLEN-1:0]         res_data,
  output logic                    wen,
  output logic [$clog2(NREG)-1:0] wa,
  output logic [VLEN-1:0]         wd,
  output logic [VLEN/8-1:0]       wbe,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned AW = $clog2(NREG);

  wb_state_e         state_q, state_d;
  logic [AW-1:0]     vd_q, vd_d;
  logic [3:0]        nregs_q, nregs_d;
  logic [1:0]        sew_q, sew_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [2:0]        beat_q, beat_d;
  logic              wen_q, wen_d;
  logic [AW-1:0]     wa_q, wa_d;
  logic [VLEN-1:0]   wd_q, wd_d;
  logic [VLEN/8-1:0] wbe_q, wbe_d;

  lmul_dec_t         cmd_dec;
  logic [AW-1:0]     grp_mask;
  logic              cmd_legal;
  logic [VLEN/8-1:0] beat_mask;

  // Command legality: known LMUL/SEW and vd aligned to the group size.
  always_comb begin
    cmd_dec   = lmul_regs(cmd_lmul_enc);
    grp_mask  = AW'(cmd_dec.regs - 4'd1);
    cmd_legal = cmd_dec.legal && sew_legal(cmd_sew_enc) && ((cmd_vd & grp_mask) == '0);
  end

  vwb_byte_mask #(
    .VLEN(VLEN),
    .VL_W(VL_W)
  ) u_byte_mask (
    .beat_i(beat_q),
    .sew_i (sew_q),
    .vl_i  (vl_q),
    .wbe_o (beat_mask)
  );

  // Next-state and registered write-port computation.
  always_comb begin
    state_d = state_q;
    vd_d    = vd_q;
    nregs_d = nregs_q;
    sew_d   = sew_q;
    vl_d    = vl_q;
    beat_d  = beat_q;
    wen_d   = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    wbe_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          vd_d    = cmd_vd;
          nregs_d = cmd_dec.regs;
          sew_d   = cmd_sew_enc[1:0];
          vl_d    = cmd_vl;
          beat_d  = 3'd0;
          if (!cmd_legal) begin
            state_d = StErr;
          end else if (cmd_vl == '0) begin
            state_d = StDone;
          end else begin
            state_d = StBurst;
          end
        end
      end
      StBurst: begin
        if (res_valid) begin
          // All-zero-mask beats are still consumed to keep the ALU stream aligned.
          wa_d   = vd_q + AW'(beat_q);
          wd_d   = res_data;
          wbe_d  = beat_mask;
          wen_d  = |beat_mask;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'(nregs_q - 4'd1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      vd_q    <= '0;
      nregs_q <= 4'd1;
      sew_q   <= 2'd0;
      vl_q    <= '0;
      beat_q  <= 3'd0;
      wen_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      wbe_q   <= '0;
    end else begin
      state_q <= state_d;
      vd_q    <= vd_d;
      nregs_q <= nregs_d;
      sew_q   <= sew_d;
      vl_q    <= vl_d;
      beat_q  <= beat_d;
      wen_q   <= wen_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      wbe_q   <= wbe_d;
    end
  end

  // Handshake and status decode from the state register.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    res_ready = (state_q == StBurst);
    busy      = (state_q == StBurst) || (state_q == StDone);
    done      = (state_q == StDone);
    err       = (state_q == StErr);
    wen       = wen_q;
    wa        = wa_q;
    wd        = wd_q;
    wbe       = wbe_q;
  end

endmodule
